piso_tx_ctrl: RTL and testbench
===============================

PISO_TX_CTRL -- requirements
Module: piso_tx_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 4, meaning clock cycles per serial bit period; legal range 1..255.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-low (0 = reset).
REQ-004 SHALL have port datos  input  4  parallel nibble to transmit, sampled only when a frame is accepted.
REQ-005 SHALL have port start  input  1  request to transmit datos; level-sampled each rising edge.
REQ-006 SHALL have port abort  input  1  synchronous cancel of the frame in progress.
REQ-007 SHALL have port salida  output  1  serial data, LSB first, feeding the downstream serial-in/parallel-out register's entrada.
REQ-008 SHALL have port bit_strobe  output  1  one-cycle pulse marking the last cycle of each bit period; drives the downstream register's enable.
REQ-009 SHALL have port busy  output  1  high while a frame is in progress, including the DONE cycle.
REQ-010 SHALL have port done  output  1  one-cycle pulse after the 4th bit completes.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE; all outputs decoded from registers only, with no combinational path from any input to any output.
REQ-012 IDLE: start=1 at a rising edge latches datos into a 4-bit shift register, clears the divider and bit counters, and moves to SHIFT.
REQ-013 SHIFT: divider counts 0..DIV-1 and wraps; salida = shift register bit 0 for the whole bit period.
REQ-014 bit_strobe SHALL be 1 exactly when state=SHIFT and divider=DIV-1; at that edge the shift register shifts right (bit 3 <- 0) and the bit counter increments.
REQ-015 The edge at which bit_strobe is high and bit counter=3 SHALL move the FSM to DONE; the bit counter wraps to 0 there and does not overflow.
REQ-016 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-017 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-018 salida SHALL be 0 in IDLE and DONE.
REQ-019 start SHALL be ignored in SHIFT and DONE (no queuing); a start held high through DONE SHALL launch a new frame at the first IDLE edge.
REQ-020 abort=1 in SHIFT or DONE SHALL return the FSM to IDLE at the next edge, with no further bit_strobe, no done pulse, and counters cleared.
REQ-021 abort SHALL take priority over start when both are high; abort in IDLE has no effect.
REQ-022 A changing datos during SHIFT SHALL NOT affect the frame in progress.
REQ-023 DIV=1 SHALL give bit_strobe high on every SHIFT cycle, i.e. 4 consecutive strobes.
REQ-024 Frame length from the start-accept edge to the done pulse SHALL be 4*DIV SHIFT cycles followed by 1 DONE cycle.

Reset
REQ-025 reset=0 SHALL immediately, without a clock, force state=IDLE, shift register=0, divider=0, bit counter=0, salida=0, bit_strobe=0, busy=0, done=0.
REQ-026 reset asserted mid-frame SHALL discard the frame; after release, no strobe or done is emitted until a new start.
REQ-027 Outputs SHALL hold their reset values until the first rising edge after reset returns to 1.

Verification
REQ-028 DIV=4, datos=4'b1011, start pulsed one cycle -> salida=1,1,0,1 for 4 cycles each; bit_strobe in cycles 4,8,12,16 after accept; done in cycle 17; busy high in cycles 1-17.
REQ-029 Same frame with salida->entrada and bit_strobe->enable into the downstream 4-bit SIPO register -> its output = 4'b1011 after the 4th strobe.
REQ-030 DIV=4, abort raised in cycle 6 of a frame -> busy=0 next cycle, only 1 strobe total, no done pulse.
REQ-031 start held high continuously, DIV=1 -> back-to-back frames of 5 cycles each (4 strobes + done); datos resampled at each accept.
REQ-032 reset pulled low in cycle 9 of a DIV=4 frame -> all outputs 0 immediately; no activity after release until start.
REQ-033 start=1 while busy=1, with datos changed -> current frame is unaltered and no extra frame follows if start is low by DONE.

Source files
------------

// File: rtl/piso_tx_if.sv
// Parallel-load / serial-out transmit handshake bundle between a frame
// producer (master) and the piso_tx_ctrl shifter (slave).
interface piso_tx_if;
  logic [3:0] datos;
  logic       start;
  logic       abort;
  logic       salida;
  logic       bit_strobe;
  logic       busy;
  logic       done;

  modport master (
    output datos, start, abort,
    input  salida, bit_strobe, busy, done
  );

  modport slave (
    input  datos, start, abort,
    output salida, bit_strobe, busy, done
  );
endinterface

// File: rtl/piso_tx_ctrl.sv
// Nibble serialiser: latches datos on start, shifts it out LSB first with one
// bit every DIV clocks, strobing the downstream SIPO enable at each bit end.
module piso_tx_ctrl #(
  parameter int unsigned DIV = 4
) (
  input  logic     clk,
  input  logic     reset,
  piso_tx_if.slave tx
);

  localparam int unsigned DIV_W  = 8;
  localparam int unsigned BIT_W  = 2;
  localparam int unsigned DATA_W = 4;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  if (DIV < 1 || DIV > 255) begin : g_bad_div
    $error("piso_tx_ctrl: DIV must be within 1..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [DIV_W-1:0]    div_q,   div_d;
  logic [BIT_W-1:0]    bit_q,   bit_d;

  logic salida_q, salida_d;
  logic strobe_q, strobe_d;
  logic busy_q,   busy_d;
  logic done_q,   done_d;

  // Next-state and datapath; abort is only meaningful once a frame is running.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    div_d   = div_q;
    bit_d   = bit_q;

    case (state_q)
      IDLE: begin
        if (tx.start) begin
          state_d = SHIFT;
          shreg_d = tx.datos;
          div_d   = '0;
          bit_d   = '0;
        end
      end

      SHIFT: begin
        if (tx.abort) begin
          state_d = IDLE;
          shreg_d = '0;
          div_d   = '0;
          bit_d   = '0;
        end else if (div_q == DIV_LAST) begin
          div_d   = '0;
          shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_LAST) begin
            state_d = DONE;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
        shreg_d = '0;
        div_d   = '0;
        bit_d   = '0;
      end

      default: begin
        state_d = IDLE;
        shreg_d = '0;
        div_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so each lands in its own flop.
  always_comb begin
    salida_d = 1'b0;
    strobe_d = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    if (state_d == SHIFT) begin
      salida_d = shreg_d[0];
      strobe_d = (div_d == DIV_LAST);
    end
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      salida_q <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      salida_q <= salida_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tx.salida     = salida_q;
  assign tx.bit_strobe = strobe_q;
  assign tx.busy       = busy_q;
  assign tx.done       = done_q;

  // Structural invariants of the registered outputs.
  a_done_busy : assert property (@(posedge clk) disable iff (!reset)
    done_q |-> busy_q);
  a_strobe_busy : assert property (@(posedge clk) disable iff (!reset)
    strobe_q |-> busy_q && !done_q);
  a_done_pulse : assert property (@(posedge clk) disable iff (!reset)
    done_q |=> !done_q);
  a_idle_quiet : assert property (@(posedge clk) disable iff (!reset)
    !busy_q |-> !salida_q && !strobe_q);

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Scoreboarded random bench for piso_tx_ctrl at DIV=4 and DIV=1, with a
// frame-position reference model and a downstream SIPO register.
module tb_piso_tx_ctrl;

  typedef struct packed {
    logic       salida;
    logic       strobe;
    logic       busy;
    logic       done;
    logic [3:0] data;
  } rec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  piso_tx_if if4 ();
  piso_tx_if if1 ();

  piso_tx_ctrl #(.DIV(4)) u_dut4 (.clk(clk), .reset(reset), .tx(if4));
  piso_tx_ctrl #(.DIV(1)) u_dut1 (.clk(clk), .reset(reset), .tx(if1));

  rec_t       q0[$];
  rec_t       q1[$];
  int         k_m   [2];
  logic [3:0] dat_m [2];
  logic       cur_start;
  logic       cur_abort;
  logic [3:0] cur_datos;
  int         checks = 0;
  int         errors = 0;

  function automatic int div_of(int d);
    return (d == 0) ? 4 : 1;
  endfunction

  // Expected outputs k cycles into a frame: k=0 idle, 1..4*dv bit periods, 4*dv+1 done.
  function automatic rec_t expect_of(int k, logic [3:0] dat, int dv);
    rec_t r;
    r      = '0;
    r.data = dat;
    if (k >= 1 && k <= 4 * dv) begin
      r.busy   = 1'b1;
      r.salida = dat[2'((k - 1) / dv)];
      r.strobe = ((k % dv) == 0);
    end else if (k == 4 * dv + 1) begin
      r.busy = 1'b1;
      r.done = 1'b1;
    end
    return r;
  endfunction

  function automatic rec_t get_out(int d);
    rec_t r;
    r = '0;
    if (d == 0) begin
      r.salida = if4.salida; r.strobe = if4.bit_strobe; r.busy = if4.busy; r.done = if4.done;
    end else begin
      r.salida = if1.salida; r.strobe = if1.bit_strobe; r.busy = if1.busy; r.done = if1.done;
    end
    return r;
  endfunction

  task automatic drive(input logic s, input logic a, input logic [3:0] dt);
    cur_start = s; cur_abort = a; cur_datos = dt;
    if4.start = s; if4.abort = a; if4.datos = dt;
    if1.start = s; if1.abort = a; if1.datos = dt;
  endtask

  task automatic model_edge(input int d);
    int dv;
    dv = div_of(d);
    if (k_m[d] == 0) begin
      if (cur_start) begin
        k_m[d]   = 1;
        dat_m[d] = cur_datos;
      end
    end else if (cur_abort || k_m[d] == 4 * dv + 1) begin
      k_m[d] = 0;
    end else begin
      k_m[d] = k_m[d] + 1;
    end
  endtask

  task automatic push_expect(input int d);
    rec_t r;
    r = expect_of(k_m[d], dat_m[d], div_of(d));
    if (d == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  // Advance one clock; leaves the caller at posedge+1 ready to drive inputs.
  task automatic step();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        model_edge(d);
        push_expect(d);
      end else begin
        k_m[d] = 0;
      end
    end
  endtask

  task automatic check_zero(input string name);
    rec_t got;
    for (int d = 0; d < 2; d++) begin
      got = get_out(d);
      checks++;
      if ({got.salida, got.strobe, got.busy, got.done} != 4'b0000) begin
        errors++;
        $display("FAIL %s dut%0d t=%0t: outputs s/st/b/d=%b%b%b%b, required 0000",
                 name, d, $time, got.salida, got.strobe, got.busy, got.done);
      end
    end
  endtask

  task automatic assert_reset_now();
    #1 reset = 1'b0;
    #1 check_zero("reset_async");
    q0.delete();
    q1.delete();
    k_m[0] = 0;
    k_m[1] = 0;
  endtask

  task automatic release_reset();
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      k_m[d] = 0;
      push_expect(d);
    end
  endtask

  // Monitor: pops one expectation per DUT per cycle and feeds a downstream SIPO.
  initial begin : monitor
    logic [3:0] sipo [2];
    rec_t got;
    rec_t exp;
    logic empty;
    sipo[0] = '0;
    sipo[1] = '0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        got = get_out(d);
        if (!reset) begin
          sipo[d] = '0;
          checks++;
          if ({got.salida, got.strobe, got.busy, got.done} != 4'b0000) begin
            errors++;
            $display("FAIL reset_hold dut%0d t=%0t: s/st/b/d=%b%b%b%b, required 0000",
                     d, $time, got.salida, got.strobe, got.busy, got.done);
          end
        end else begin
          empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
          checks++;
          if (empty) begin
            errors++;
            $display("FAIL scoreboard_empty dut%0d t=%0t: no expectation queued", d, $time);
          end else begin
            exp = (d == 0) ? q0.pop_front() : q1.pop_front();
            if ({got.salida, got.strobe, got.busy, got.done} !=
                {exp.salida, exp.strobe, exp.busy, exp.done}) begin
              errors++;
              $display("FAIL outputs dut%0d t=%0t: s/st/b/d got %b%b%b%b, required %b%b%b%b",
                       d, $time, got.salida, got.strobe, got.busy, got.done,
                       exp.salida, exp.strobe, exp.busy, exp.done);
            end
            if (got.strobe) sipo[d] = {got.salida, sipo[d][3:1]};
            if (exp.done) begin
              checks++;
              if (sipo[d] != exp.data) begin
                errors++;
                $display("FAIL sipo_word dut%0d t=%0t: got %b, required %b",
                         d, $time, sipo[d], exp.data);
              end
            end
          end
        end
      end
    end
  end

  initial begin : stimulus
    k_m[0] = 0; k_m[1] = 0;
    dat_m[0] = '0; dat_m[1] = '0;
    reset = 1'b0;
    drive(1'b0, 1'b0, 4'h0);
    #2 check_zero("reset_initial");
    step();
    step();
    release_reset();

    // Reference frame 1011 with a one-cycle start pulse.
    step();
    drive(1'b1, 1'b0, 4'b1011);
    step();
    drive(1'b0, 1'b0, 4'b0100);
    repeat (22) step();

    // Abort raised in cycle 6 of a frame.
    drive(1'b1, 1'b0, 4'b0101);
    step();
    drive(1'b0, 1'b0, 4'($urandom));
    repeat (5) step();
    drive(1'b0, 1'b1, 4'($urandom));
    step();
    drive(1'b0, 1'b0, 4'h0);
    repeat (10) step();

    // Start held high with datos changing every cycle.
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, 1'b0, 4'($urandom));
      step();
    end
    drive(1'b0, 1'b0, 4'h0);
    repeat (12) step();

    // Start re-asserted while busy, dropped before DONE.
    drive(1'b1, 1'b0, 4'b1110);
    step();
    drive(1'b0, 1'b0, 4'b0001);
    step();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 4'($urandom));
      step();
    end
    drive(1'b0, 1'b0, 4'h0);
    repeat (14) step();

    // Reset pulled in cycle 9 of a frame, then silence until a new start.
    drive(1'b1, 1'b0, 4'b1101);
    step();
    drive(1'b0, 1'b0, 4'h0);
    repeat (8) step();
    assert_reset_now();
    step();
    step();
    release_reset();
    repeat (10) step();

    // Random traffic including start/abort collisions.
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, 4'($urandom));
      step();
    end
    drive(1'b0, 1'b0, 4'h0);
    repeat (30) step();

    @(negedge clk);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d expectations left, required 0/0", q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
